// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and the ALU control decoder.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_MEM_ADDR   = 4'd2,
    S_MEM_READ   = 4'd3,
    S_MEM_WB     = 4'd4,
    S_MEM_WRITE  = 4'd5,
    S_EXECUTE    = 4'd6,
    S_R_COMPLETE = 4'd7,
    S_BRANCH     = 4'd8,
    S_JUMP       = 4'd9,
    S_ADDI_EXEC  = 4'd10,
    S_ADDI_WB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences each instruction
// and drives datapath selects/strobes, stalling on the memory ready handshake.
//
// state        | meaning
// FETCH        | read instruction at PC, PC+4 (waits for memReady)
// DECODE       | read registers, compute branch target, dispatch on opcode
// MEM_ADDR     | compute lw/sw effective address
// MEM_READ     | load data access (waits for memReady)
// MEM_WB       | write loaded data to rt
// MEM_WRITE    | store data access (waits for memReady)
// EXECUTE      | R-type ALU operation
// R_COMPLETE   | write ALU result to rd
// BRANCH       | compare, conditionally load branch target
// JUMP         | load jump target
// ADDI_EXEC    | add sign-extended immediate
// ADDI_WB      | write ALU result to rt
module multi_cycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       irWrite,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       illegalOp,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_next;
  end

  assign state = state_q;

  always_comb begin
    state_next = S_FETCH;
    unique case (state_q)
      S_FETCH:     state_next = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDI_EXEC;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_next = S_MEM_READ;
        else if (opcode == OP_SW) state_next = S_MEM_WRITE;
        else                      state_next = S_FETCH;
      end
      S_MEM_READ:  state_next = memReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_next = memReady ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_next = S_R_COMPLETE;
      S_ADDI_EXEC: state_next = S_ADDI_WB;
      default:     state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    memToReg    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = ALUSRCB_B;
    aluOp       = ALUOP_ADD;
    pcSource    = PCSRC_ALU;
    illegalOp   = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = ALUSRCB_FOUR;
        irWrite = memReady;
        pcWrite = memReady;
      end
      S_DECODE: begin
        aluSrcB = ALUSRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegalOp = 1'b0;
          default:                                       illegalOp = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = ALUSRCB_IMM;
      end
      S_MEM_READ: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      S_MEM_WB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      S_MEM_WRITE: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      S_EXECUTE: begin
        aluSrcA = 1'b1;
        aluOp   = ALUOP_FUNCT;
      end
      S_R_COMPLETE: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = ALUOP_SUB;
        pcWriteCond = 1'b1;
        pcSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = PCSRC_JUMP;
      end
      S_ADDI_EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = ALUSRCB_IMM;
      end
      S_ADDI_WB:   regWrite = 1'b1;
      default: ;
    endcase
    // Reset forces FETCH asynchronously; strobes must not fire while it is held.
    if (rst) begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      irWrite     = 1'b0;
      memWrite    = 1'b0;
      regWrite    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: expected state/output per cycle is
// queued per instruction and compared as the controller steps.
module tb_multi_cycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic       ready;
    logic [3:0] st;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg;
  logic       irWrite, regDst, regWrite, aluSrcA, illegalOp;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  step_t sb[$];
  ctl_t  obs;
  ctl_t  exp_c;

  multi_cycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
    .irWrite(irWrite), .regDst(regDst), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .illegalOp(illegalOp), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
                regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp};

  function automatic ctl_t expect_ctl(input logic [3:0] st, input logic rdy,
                                      input logic [5:0] op);
    ctl_t c = '0;
    case (st)
      4'd0: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      4'd1: begin
        c.alu_src_b = 2'b11;
        c.illegal = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                      op == 6'b000100 || op == 6'b000010 || op == 6'b001000);
      end
      4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4'd3:  begin c.mem_read = 1; c.ior_d = 1; end
      4'd4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      4'd5:  begin c.mem_write = 1; c.ior_d = 1; end
      4'd6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      4'd7:  begin c.reg_write = 1; c.reg_dst = 1; end
      4'd8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      4'd9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
      4'd10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4'd11: c.reg_write = 1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic push(input logic [5:0] op, input logic rdy, input logic [3:0] st);
    step_t s;
    s.op = op; s.ready = rdy; s.st = st;
    sb.push_back(s);
  endtask

  initial begin
    rst = 1'b1; opcode = 6'b000000; memReady = 1'b1;
    #2;
    exp_c = expect_ctl(4'd0, 1'b1, 6'b000000);
    exp_c.pc_write = 1'b0; exp_c.ir_write = 1'b0;
    checks++;
    assert (state === 4'd0) else begin errors++; $error("FAIL reset_state observed=%0d expected=0", state); end
    checks++;
    assert (obs === exp_c) else begin errors++; $error("FAIL reset_outputs observed=%h expected=%h", obs, exp_c); end

    // Walk an R-type into EXECUTE, then reset between clock edges.
    @(negedge clk); rst = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    checks++;
    assert (state === 4'd6) else begin errors++; $error("FAIL reach_execute observed=%0d expected=6", state); end
    rst = 1'b1; #1;
    checks++;
    assert (state === 4'd0) else begin errors++; $error("FAIL async_rst_state observed=%0d expected=0", state); end
    checks++;
    assert (regWrite === 1'b0 && irWrite === 1'b0 && pcWrite === 1'b0)
      else begin errors++; $error("FAIL async_rst_strobes observed=%b%b%b expected=000", regWrite, irWrite, pcWrite); end
    checks++;
    assert (memRead === 1'b1 && aluSrcB === 2'b01)
      else begin errors++; $error("FAIL async_rst_fetch observed=%b/%b expected=1/01", memRead, aluSrcB); end
    @(negedge clk); rst = 1'b0; memReady = 1'b0;

    // R-type
    push(6'h00, 1, 0); push(6'h00, 1, 1); push(6'h00, 1, 6); push(6'h00, 1, 7);
    // lw, two wait cycles in MEM_READ
    push(6'h23, 1, 0); push(6'h23, 1, 1); push(6'h23, 1, 2);
    push(6'h23, 0, 3); push(6'h23, 0, 3); push(6'h23, 1, 3); push(6'h23, 1, 4);
    // sw with one FETCH stall
    push(6'h2b, 0, 0); push(6'h2b, 1, 0); push(6'h2b, 1, 1); push(6'h2b, 1, 2); push(6'h2b, 1, 5);
    // beq
    push(6'h04, 1, 0); push(6'h04, 1, 1); push(6'h04, 1, 8);
    // j
    push(6'h02, 1, 0); push(6'h02, 1, 1); push(6'h02, 1, 9);
    // addi
    push(6'h08, 1, 0); push(6'h08, 1, 1); push(6'h08, 1, 10); push(6'h08, 1, 11);
    // sw with one wait in MEM_WRITE
    push(6'h2b, 1, 0); push(6'h2b, 1, 1); push(6'h2b, 1, 2); push(6'h2b, 0, 5); push(6'h2b, 1, 5);
    // illegal opcode
    push(6'h3f, 1, 0); push(6'h3f, 1, 1);
    push(6'h3f, 0, 0);

    while (sb.size() > 0) begin
      step_t s;
      @(negedge clk);
      s = sb.pop_front();
      opcode = s.op; memReady = s.ready;
      #1;
      exp_c = expect_ctl(s.st, s.ready, s.op);
      checks++;
      assert (state === s.st)
        else begin errors++; $error("FAIL state op=%h observed=%0d expected=%0d", s.op, state, s.st); end
      checks++;
      assert (obs === exp_c)
        else begin errors++; $error("FAIL outputs st=%0d observed=%h expected=%h", s.st, obs, exp_c); end
      checks++;
      assert (aluOp !== 2'b11)
        else begin errors++; $error("FAIL aluop_11 observed=%b expected!=11", aluOp); end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
